// File: rtl/tt_um_alexlowl_btn_decoder.sv
// rtl/tt_um_alexlowl_btn_decoder.sv - push-button synchroniser, debouncer and run/speed decoder
module tt_um_alexlowl_btn_decoder #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int SPEED_LEVELS    = 8,
    parameter int SPEED_RESET     = 3,
    localparam int SW = (SPEED_LEVELS > 1) ? $clog2(SPEED_LEVELS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [2:0]    btn_raw,
    output logic [2:0]    btn_state,
    output logic [2:0]    btn_press,
    output logic          running,
    output logic [SW-1:0] speed_level,
    output logic          speed_change
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SPEED_MAX  = SW'(SPEED_LEVELS - 1);
    localparam logic [SW-1:0] SPEED_INIT = SW'(SPEED_RESET);

    logic [2:0]    sync1, sync2;
    logic [2:0]    state_q, state_next;
    logic [2:0]    press_q, press_next;
    logic [CW-1:0] cnt_q    [3];
    logic [CW-1:0] cnt_next [3];
    logic          running_q, running_next;
    logic [SW-1:0] speed_q, speed_next;
    logic          change_q, change_next;

    // Per-button debounce: a level is accepted after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        state_next = state_q;
        press_next = '0;
        for (int i = 0; i < 3; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    state_next[i] = sync2[i];
                    press_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Run toggle and saturating speed step, decoded from the presses accepted this edge.
    always_comb begin
        running_next = running_q ^ press_next[0];
        speed_next   = speed_q;
        if (press_next[1] && !press_next[2] && speed_q != SPEED_MAX) begin
            speed_next = speed_q + SW'(1);
        end else if (press_next[2] && !press_next[1] && speed_q != '0) begin
            speed_next = speed_q - SW'(1);
        end
        change_next = (speed_next != speed_q);
    end

    // State registers; pulse registers are cleared while disabled so they cannot re-fire on resume.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            state_q   <= '0;
            press_q   <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            running_q <= 1'b0;
            speed_q   <= SPEED_INIT;
            change_q  <= 1'b0;
        end else if (ena) begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            state_q   <= state_next;
            press_q   <= press_next;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_next[i];
            running_q <= running_next;
            speed_q   <= speed_next;
            change_q  <= change_next;
        end else begin
            press_q  <= '0;
            change_q <= 1'b0;
        end
    end

    assign btn_state    = state_q;
    assign btn_press    = press_q & {3{ena}};
    assign running      = running_q;
    assign speed_level  = speed_q;
    assign speed_change = change_q & ena;

endmodule

// File: tb/tb_tt_um_alexlowl_btn_decoder.sv
// tb/tb_tt_um_alexlowl_btn_decoder.sv - self-checking bench for tt_um_alexlowl_btn_decoder
module tb_tt_um_alexlowl_btn_decoder;

    localparam int DEB = 8;
    localparam int LEVELS = 8;
    localparam int SRESET = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [2:0] btn_raw = '0;
    logic [2:0] btn_state;
    logic [2:0] btn_press;
    logic       running;
    logic [2:0] speed_level;
    logic       speed_change;

    tt_um_alexlowl_btn_decoder #(
        .DEBOUNCE_CYCLES(DEB),
        .SPEED_LEVELS(LEVELS),
        .SPEED_RESET(SRESET)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .btn_raw(btn_raw),
        .btn_state(btn_state),
        .btn_press(btn_press),
        .running(running),
        .speed_level(speed_level),
        .speed_change(speed_change)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: the debouncer sees the raw level from two enabled edges earlier and
    // accepts it once it has disagreed with the accepted level for DEB edges in a row.
    logic [2:0] m_p1 = '0, m_p2 = '0, m_state = '0, m_press = '0;
    int         m_run [3] = '{0, 0, 0};
    logic       m_running = 1'b0;
    logic       m_change = 1'b0;
    int         m_speed = SRESET;
    int         m_nv;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_p1 = '0; m_p2 = '0; m_state = '0; m_press = '0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            m_running = 1'b0; m_change = 1'b0; m_speed = SRESET;
        end else if (ena) begin
            m_press = '0;
            for (int i = 0; i < 3; i++) begin
                if (m_p2[i] != m_state[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB) begin
                        m_state[i] = m_p2[i];
                        m_press[i] = m_p2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_p2 = m_p1;
            m_p1 = btn_raw;
            m_running = m_running ^ m_press[0];
            m_nv = m_speed + int'(m_press[1]) - int'(m_press[2]);
            if (m_nv < 0) m_nv = 0;
            if (m_nv > LEVELS - 1) m_nv = LEVELS - 1;
            m_change = (m_nv != m_speed);
            m_speed = m_nv;
        end else begin
            m_press = '0;
            m_change = 1'b0;
        end
    end

    int press_seen [3];
    int change_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("btn_state", 32'(btn_state), 32'(m_state));
        chk("btn_press", 32'(btn_press), 32'(ena ? m_press : 3'b000));
        chk("running", 32'(running), 32'(m_running));
        chk("speed_level", 32'(speed_level), 32'(m_speed));
        chk("speed_change", 32'(speed_change), 32'(ena ? m_change : 1'b0));
        for (int i = 0; i < 3; i++) if (btn_press[i]) press_seen[i]++;
        if (speed_change) change_seen++;
    endtask

    task automatic clear_tally();
        for (int i = 0; i < 3; i++) press_seen[i] = 0;
        change_seen = 0;
    endtask

    task automatic cycle(input logic [2:0] raw, input logic en, input logic rst);
        btn_raw = raw;
        ena = en;
        rst_n = rst;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic press(input logic [2:0] mask);
        for (int j = 0; j < 12; j++) cycle(mask, 1'b1, 1'b1);
        for (int j = 0; j < 12; j++) cycle(3'b000, 1'b1, 1'b1);
    endtask

    int pulse_at;
    int hold;
    logic [2:0] r;
    int exp_up [6] = '{4, 5, 6, 7, 7, 7};

    initial begin
        clear_tally();
        @(negedge clk);
        // Reset for 300 ns
        for (int j = 0; j < 15; j++) cycle(3'b000, 1'b1, 1'b0);
        chk("reset_state", 32'(btn_state), 32'd0);
        chk("reset_speed", 32'(speed_level), 32'd3);
        chk("reset_running", 32'(running), 32'd0);

        // 1: pause press, pulse timing and toggle
        clear_tally();
        pulse_at = -1;
        for (int j = 1; j <= 15; j++) begin
            cycle(3'b001, 1'b1, 1'b1);
            if (btn_press[0] && pulse_at < 0) pulse_at = j;
        end
        for (int j = 0; j < 12; j++) cycle(3'b000, 1'b1, 1'b1);
        chk("t1_pulse_edge", 32'(pulse_at), 32'd10);
        chk("t1_pulse_count", 32'(press_seen[0]), 32'd1);
        chk("t1_running_on", 32'(running), 32'd1);
        press(3'b001);
        chk("t1_running_off", 32'(running), 32'd0);

        // 2: glitch and bounce on faster
        clear_tally();
        for (int j = 0; j < 5; j++) cycle(3'b010, 1'b1, 1'b1);
        for (int j = 0; j < 12; j++) cycle(3'b000, 1'b1, 1'b1);
        for (int j = 0; j < 3; j++) cycle(3'b010, 1'b1, 1'b1);
        cycle(3'b000, 1'b1, 1'b1);
        for (int j = 0; j < 3; j++) cycle(3'b010, 1'b1, 1'b1);
        for (int j = 0; j < 12; j++) cycle(3'b000, 1'b1, 1'b1);
        chk("t2_no_press", 32'(press_seen[1]), 32'd0);
        chk("t2_speed", 32'(speed_level), 32'd3);

        // 3: faster x6 with saturation
        clear_tally();
        for (int n = 0; n < 6; n++) begin
            press(3'b010);
            chk("t3_speed_step", 32'(speed_level), 32'(exp_up[n]));
        end
        chk("t3_change_count", 32'(change_seen), 32'd4);

        // 4: slower x9 down to 0
        clear_tally();
        for (int n = 0; n < 9; n++) press(3'b100);
        chk("t4_speed_floor", 32'(speed_level), 32'd0);
        chk("t4_change_count", 32'(change_seen), 32'd7);

        // 5: faster and slower together
        clear_tally();
        pulse_at = 0;
        for (int j = 0; j < 12; j++) begin
            cycle(3'b110, 1'b1, 1'b1);
            if (btn_press == 3'b110) pulse_at++;
        end
        for (int j = 0; j < 12; j++) cycle(3'b000, 1'b1, 1'b1);
        chk("t5_joint_pulse", 32'(pulse_at), 32'd1);
        chk("t5_speed", 32'(speed_level), 32'd0);
        chk("t5_no_change", 32'(change_seen), 32'd0);

        // 6: reset mid-debounce with pause held
        press(3'b001);
        for (int j = 1; j <= 6; j++) cycle(3'b001, 1'b1, 1'b1);
        cycle(3'b001, 1'b1, 1'b0);
        cycle(3'b001, 1'b1, 1'b0);
        chk("t6_running_reset", 32'(running), 32'd0);
        chk("t6_speed_reset", 32'(speed_level), 32'd3);
        clear_tally();
        pulse_at = -1;
        for (int j = 1; j <= 14; j++) begin
            cycle(3'b001, 1'b1, 1'b1);
            if (btn_press[0] && pulse_at < 0) pulse_at = j;
        end
        chk("t6_post_reset_edge", 32'(pulse_at), 32'd10);
        for (int j = 0; j < 12; j++) cycle(3'b000, 1'b1, 1'b1);

        // ena=0 across the acceptance point delays the pulse
        clear_tally();
        for (int j = 1; j <= 9; j++) cycle(3'b001, 1'b1, 1'b1);
        for (int j = 10; j <= 14; j++) cycle(3'b001, 1'b0, 1'b1);
        chk("t6_ena_held_press", 32'(press_seen[0]), 32'd0);
        cycle(3'b001, 1'b1, 1'b1);
        chk("t6_ena_resume_press", 32'(btn_press[0]), 32'd1);
        for (int j = 0; j < 12; j++) cycle(3'b000, 1'b1, 1'b1);

        // Randomised traffic against the reference
        hold = 0;
        r = '0;
        for (int n = 0; n < 800; n++) begin
            if (hold == 0) begin
                r = 3'($urandom_range(0, 7));
                hold = $urandom_range(1, 20);
            end
            hold--;
            cycle(r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
